// File: rtl/fetch_rf_1p_banked_pkg.sv
// Shared geometry defaults and port-arbitration helper for the banked fetch buffer.
// Optional feature macro used by the top: FETCH_RF_OREG_EN.
package fetch_rf_1p_banked_pkg;

  localparam int PIXEL_WIDTH     = 8;
  localparam int FETCH_RF_ADDR_W = 6;
  localparam int FETCH_RF_BANK_W = 8 * PIXEL_WIDTH;
  localparam int FETCH_RF_NBANK  = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_PEND = 2'd2,
    GNT_NEW  = 2'd3
  } port_gnt_e;

  // Single array port: write beats the parked read, which beats a new read.
  function automatic port_gnt_e port_arbitrate(input logic wr_en,
                                               input logic pend_vld,
                                               input logic rd_en);
    if (wr_en)         return GNT_WR;
    else if (pend_vld) return GNT_PEND;
    else if (rd_en)    return GNT_NEW;
    else               return GNT_NONE;
  endfunction

endpackage

// File: rtl/fetch_rf_1p_banked_bank.sv
// One single-port register-file bank (active-low chip/write enables, registered read).
// Contents are never reset; the read register only updates on read cycles.
module fetch_rf_1p_banked_bank
  import fetch_rf_1p_banked_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_RF_ADDR_W,
  parameter int DATA_WIDTH = FETCH_RF_BANK_W
) (
  input  logic                  clk,
  input  logic                  i_cen,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!i_cen) begin
      if (!i_wen) r_mem[i_addr] <= i_data;
      else        r_q           <= r_mem[i_addr];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_rf_1p_banked.sv
// Banked single-port fetch buffer: write-priority arbitration, one-entry parked read, valid pipeline.
// Define FETCH_RF_OREG_EN to add a registered output stage (read latency 2 instead of 1).
module fetch_rf_1p_banked
  import fetch_rf_1p_banked_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_RF_ADDR_W,
  parameter int BANK_WIDTH = FETCH_RF_BANK_W,
  parameter int NUM_BANK   = FETCH_RF_NBANK
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wrif_en_i,
  input  logic [ADDR_WIDTH-1:0]          wrif_addr_i,
  input  logic [NUM_BANK-1:0]            wrif_bank_i,
  input  logic [NUM_BANK*BANK_WIDTH-1:0] wrif_data_i,
  input  logic                           rdif_en_i,
  input  logic [ADDR_WIDTH-1:0]          rdif_addr_i,
  output logic                           rdif_rdy_o,
  output logic                           rdif_valid_o,
  output logic [NUM_BANK*BANK_WIDTH-1:0] rdif_pdata_o
);

  localparam int W = NUM_BANK * BANK_WIDTH;

  logic                  r_pend_vld;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic                  r_rd_vld;
  port_gnt_e             w_gnt;
  logic                  w_rd_issue;
  logic                  w_park;
  logic                  w_port_cen_n;
  logic [ADDR_WIDTH-1:0] w_port_addr;
  logic [W-1:0]          w_rd_data;

  assign w_gnt        = port_arbitrate(wrif_en_i, r_pend_vld, rdif_en_i);
  assign w_rd_issue   = (w_gnt == GNT_PEND) || (w_gnt == GNT_NEW);
  assign w_park       = rdif_en_i && rdif_rdy_o && wrif_en_i;
  assign w_port_cen_n = (w_gnt == GNT_NONE);
  assign w_port_addr  = wrif_en_i  ? wrif_addr_i :
                        r_pend_vld ? r_pend_addr : rdif_addr_i;

  assign rdif_rdy_o = ~r_pend_vld;

  generate
    for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
      fetch_rf_1p_banked_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (BANK_WIDTH)
      ) u_bank (
        .clk    (clk),
        .i_cen  (w_port_cen_n),
        .i_wen  (~(wrif_en_i & wrif_bank_i[gi])),
        .i_addr (w_port_addr),
        .i_data (wrif_data_i[gi*BANK_WIDTH +: BANK_WIDTH]),
        .o_q    (w_rd_data[gi*BANK_WIDTH +: BANK_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_rd_vld    <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_issue;
      if (w_park) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= rdif_addr_i;
      end else if (w_gnt == GNT_PEND) begin
        r_pend_vld  <= 1'b0;
      end
    end
  end

`ifdef FETCH_RF_OREG_EN
  logic         r_out_vld;
  logic [W-1:0] r_pdata;

  // Output register captures only on a returning read, so data holds between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_vld <= 1'b0;
      r_pdata   <= '0;
    end else begin
      r_out_vld <= r_rd_vld;
      if (r_rd_vld) r_pdata <= w_rd_data;
    end
  end

  assign rdif_valid_o = r_out_vld;
  assign rdif_pdata_o = r_pdata;
`else
  assign rdif_valid_o = r_rd_vld;
  assign rdif_pdata_o = w_rd_data;
`endif

endmodule
